lut_eval_ctrl: RTL and testbench
================================

# lut_eval_ctrl

Configuration and sharing controller for the 16:1 LUT mux datapath. It loads the 16-bit truth table serially through a valid/ready bit stream and commits it atomically to the LUT. It then arbitrates evaluation requests from NREQ requesters round-robin, driving the LUT select and returning the registered LUT result tagged with the requester ID. It sits between the configuration/host logic and a single LUT instance, which it drives through LUT_input/LUT_sel and reads through LUT_output.

## Interface
- NREQ, 4, number of evaluation requesters (2..8)
- IDW, $clog2(NREQ), width of rsp_id
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_start  in  1  begin (or restart) a truth-table load
- cfg_valid  in  1  cfg_bit is valid
- cfg_bit  in  1  truth-table bit, LSB (entry 0) first
- cfg_ready  out  1  controller accepts a bit this cycle
- cfg_done  out  1  one-cycle pulse: new table committed
- configured  out  1  a table has been committed since reset
- req  in  NREQ  per-requester evaluation request, level
- req_sel  in  4*NREQ  requester i's select is req_sel[4i+3:4i]
- gnt  out  NREQ  one-hot grant pulse
- rsp_valid  out  1  one-cycle pulse, result valid
- rsp_data  out  1  LUT result
- rsp_id  out  IDW  index of granted requester
- LUT_input  out  16  committed truth table to LUT
- LUT_sel  out  4  registered select to LUT
- LUT_output  in  1  combinational LUT result

## Operation
- States: UNCFG, LOAD, IDLE, EVAL.
- Reset: state UNCFG. All outputs 0: cfg_ready, cfg_done, configured, gnt, rsp_valid, rsp_data, rsp_id, LUT_input, LUT_sel. RR pointer = NREQ-1, so requester 0 is first.
- UNCFG/IDLE: cfg_start moves to LOAD, clears the 4-bit count and the 16-bit shadow register. In IDLE, cfg_start has priority over req; pending reqs wait.
- LOAD: cfg_ready=1. Each cfg_valid&&cfg_ready writes cfg_bit into shadow[count], then count++.
  - cfg_start in LOAD restarts: count=0, shadow discarded.
  - LUT_input is unchanged during LOAD.
- On the 16th accepted bit: LUT_input<=shadow (including the final bit), configured<=1, cfg_done pulses, state IDLE.
- cfg_valid outside LOAD is ignored. cfg_start in EVAL is ignored.
- IDLE with configured=1 and |req: the arbiter picks the first asserted req starting at pointer+1, modulo NREQ. Next edge: gnt[w]<=1, LUT_sel<=req_sel[w], pointer<=w, state EVAL.
- EVAL: no arbitration. Next edge: rsp_data<=LUT_output, rsp_id<=w, rsp_valid<=1, state IDLE.
- Requester rule: hold req and req_sel stable until gnt; drop req in the gnt cycle. A req still high in the following IDLE cycle is a new request.
- Requests while UNCFG or LOAD are not granted; they remain pending.
- LUT_sel holds its last value between evaluations.

## Timing
- Load: cfg_done asserts the cycle after the 16th handshake. Minimum 16 cycles of cfg_ready. LUT_input changes on the same edge as cfg_done.
- Eval: req sampled in cycle N (IDLE) -> gnt and LUT_sel in N+1 -> rsp_valid in N+2. Latency is 2 cycles; throughput is one evaluation per 2 cycles.
- All-requesters-busy: grants rotate 0,1,...,NREQ-1 with one grant every 2 cycles. No starvation; worst-case wait is 2*NREQ cycles.
- rst mid-LOAD or mid-EVAL: the next cycle shows reset values. An in-flight rsp_valid is never emitted. The table is lost and configured=0.

## Structure
- Package lut_ctrl_pkg: state enum (UNCFG, LOAD, IDLE, EVAL), LUT_DEPTH=16, SEL_W=4.
- Sub-module lut_rr_arb: combinational round-robin arbiter.
  - Inputs: req[NREQ-1:0], ptr.
  - Outputs: any, winner index.
- The top level holds the FSM, shadow/count, and output registers.

## Test plan
- Reset, cfg_start, 16 bits of 16'h8001 LSB first -> cfg_done one cycle after the 16th bit; LUT_input=16'h8001; configured=1; cfg_ready=0.
- Table 16'h8001, req[2] with sel 4'hF -> gnt=4'b0100 at N+1, LUT_sel=F; rsp_valid at N+2 with rsp_data=1, rsp_id=2. Repeat with sel 4'h5 -> rsp_data=0.
- req=4'b1111 held, each dropped only for its gnt cycle -> grant order 0,1,2,3,0, grants 2 cycles apart. Each rsp_id matches its prior grant.
- req[1] asserted before any load -> no gnt. Load completes -> gnt[1] on the first IDLE cycle. cfg_start and req[0] in the same IDLE cycle -> LOAD entered, gnt[0] only after cfg_done.
- Table 16'h00FF committed, then cfg_start, 7 bits, cfg_start again, 16 bits of 16'hA5A5 -> LUT_input stays 16'h00FF until the final bit, then becomes 16'hA5A5; exactly one cfg_done.
- rst asserted in the EVAL cycle -> no rsp_valid; all outputs 0 the next cycle; req ignored until a new table is loaded.

Source files
------------

// File: rtl/lut_ctrl_pkg.sv
// rtl/lut_ctrl_pkg.sv - shared types and constants for the LUT evaluation controller
package lut_ctrl_pkg;

    localparam int LUT_DEPTH = 16;
    localparam int SEL_W     = 4;
    localparam int CNT_W     = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        IDLE  = 2'd2,
        EVAL  = 2'd3
    } state_t;

endpackage

// File: rtl/lut_rr_arb.sv
// rtl/lut_rr_arb.sv - combinational round-robin arbiter, search starts after ptr
module lut_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  winner
);

    logic [IDW-1:0] idx;

    // Scan from farthest to nearest so the closest asserted request after ptr wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/lut_eval_ctrl.sv
// rtl/lut_eval_ctrl.sv - serial truth-table loader and round-robin evaluation sharer for one 16:1 LUT
module lut_eval_ctrl
    import lut_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic                  cfg_bit,
    output logic                  cfg_ready,
    output logic                  cfg_done,
    output logic                  configured,
    input  logic [NREQ-1:0]       req,
    input  logic [SEL_W*NREQ-1:0] req_sel,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic                  rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic [LUT_DEPTH-1:0]  LUT_input,
    output logic [SEL_W-1:0]      LUT_sel,
    input  logic                  LUT_output
);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     count;
    logic [LUT_DEPTH-1:0] shadow, shadow_nxt;
    logic [IDW-1:0]       ptr, win, win_q;
    logic                 any;
    logic                 load_clr, bit_acc, commit, grant_en, eval_en;
    logic [SEL_W-1:0]     sel_arr [NREQ];

    lut_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (win)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            sel_arr[i] = req_sel[i*SEL_W +: SEL_W];
        end
    end

    // Shadow including the bit being accepted this cycle, so commit captures all 16.
    always_comb begin
        shadow_nxt        = shadow;
        shadow_nxt[count] = cfg_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= UNCFG;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNCFG: if (cfg_start) state_nxt = LOAD;
            LOAD:  if (!cfg_start && cfg_valid && count == CNT_W'(LUT_DEPTH - 1)) state_nxt = IDLE;
            IDLE: begin
                if (cfg_start)              state_nxt = LOAD;
                else if (configured && any) state_nxt = EVAL;
            end
            EVAL:  state_nxt = IDLE;
            default: state_nxt = UNCFG;
        endcase
    end

    // Restart inside LOAD takes precedence over a simultaneous bit.
    always_comb begin
        cfg_ready = (state == LOAD);
        load_clr  = cfg_start && (state != EVAL);
        bit_acc   = (state == LOAD) && cfg_valid && !cfg_start;
        commit    = bit_acc && (count == CNT_W'(LUT_DEPTH - 1));
        grant_en  = (state == IDLE) && !cfg_start && configured && any;
        eval_en   = (state == EVAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            shadow     <= '0;
            cfg_done   <= 1'b0;
            configured <= 1'b0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 1'b0;
            rsp_id     <= '0;
            LUT_input  <= '0;
            LUT_sel    <= '0;
            ptr        <= IDW'(NREQ - 1);
            win_q      <= '0;
        end else begin
            cfg_done  <= 1'b0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            if (load_clr) begin
                count  <= '0;
                shadow <= '0;
            end else if (bit_acc) begin
                shadow <= shadow_nxt;
                count  <= count + CNT_W'(1);
            end
            if (commit) begin
                LUT_input  <= shadow_nxt;
                configured <= 1'b1;
                cfg_done   <= 1'b1;
            end
            if (grant_en) begin
                gnt     <= NREQ'(1) << win;
                LUT_sel <= sel_arr[win];
                ptr     <= win;
                win_q   <= win;
            end
            if (eval_en) begin
                rsp_data  <= LUT_output;
                rsp_id    <= win_q;
                rsp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lut_eval_ctrl.sv
// tb/tb_lut_eval_ctrl.sv - directed self-checking bench for lut_eval_ctrl
module tb_lut_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_valid, cfg_bit;
    logic        cfg_ready, cfg_done, configured;
    logic [3:0]  req;
    logic [15:0] req_sel;
    logic [3:0]  gnt;
    logic        rsp_valid, rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] LUT_input;
    logic [3:0]  LUT_sel;
    logic        LUT_output;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    assign LUT_output = LUT_input[LUT_sel];

    lut_eval_ctrl #(.NREQ(4), .IDW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .configured (configured),
        .req        (req),
        .req_sel    (req_sel),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .LUT_input  (LUT_input),
        .LUT_sel    (LUT_sel),
        .LUT_output (LUT_output)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (cfg_done === 1'b1) done_seen++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  32'(cfg_ready),  0);
        chk({tag, "_done"},   32'(cfg_done),   0);
        chk({tag, "_cfgd"},   32'(configured), 0);
        chk({tag, "_gnt"},    32'(gnt),        0);
        chk({tag, "_rspv"},   32'(rsp_valid),  0);
        chk({tag, "_rspd"},   32'(rsp_data),   0);
        chk({tag, "_rspid"},  32'(rsp_id),     0);
        chk({tag, "_lutin"},  32'(LUT_input),  0);
        chk({tag, "_lutsel"}, 32'(LUT_sel),    0);
    endtask

    // Shifts 16 bits LSB first; the caller has already entered LOAD.
    task automatic shift_bits(input logic [15:0] val, input logic [15:0] hold, input string tag);
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = val[i];
            step();
            if (i < 15) begin
                chk({tag, "_hold"}, 32'(LUT_input), 32'(hold));
                chk({tag, "_nodone"}, 32'(cfg_done), 0);
            end
        end
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        chk({tag, "_done"}, 32'(cfg_done), 1);
        chk({tag, "_table"}, 32'(LUT_input), 32'(val));
        chk({tag, "_cfgd"}, 32'(configured), 1);
        chk({tag, "_rdy_off"}, 32'(cfg_ready), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] sel_hold;
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        req = '0; req_sel = '0;

        // Reset values
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;

        // Load 16'h8001
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("load1_ready", 32'(cfg_ready), 1);
        shift_bits(16'h8001, 16'h0000, "load1");
        step();
        chk("load1_pulse", 32'(cfg_done), 0);

        // Single evaluation, sel F -> 1
        req = 4'b0100; req_sel = 16'h0F00;
        step();
        chk("ev1_gnt", 32'(gnt), 32'h4);
        chk("ev1_sel", 32'(LUT_sel), 32'hF);
        chk("ev1_novalid", 32'(rsp_valid), 0);
        req = '0;
        step();
        chk("ev1_valid", 32'(rsp_valid), 1);
        chk("ev1_data", 32'(rsp_data), 1);
        chk("ev1_id", 32'(rsp_id), 2);
        chk("ev1_gnt_off", 32'(gnt), 0);

        // Same requester, sel 5 -> 0
        req = 4'b0100; req_sel = 16'h0500;
        step();
        chk("ev2_gnt", 32'(gnt), 32'h4);
        chk("ev2_sel", 32'(LUT_sel), 32'h5);
        req = '0;
        step();
        chk("ev2_valid", 32'(rsp_valid), 1);
        chk("ev2_data", 32'(rsp_data), 0);
        chk("ev2_id", 32'(rsp_id), 2);
        step();
        chk("ev2_pulse", 32'(rsp_valid), 0);
        chk("ev2_selhold", 32'(LUT_sel), 32'h5);

        // Requester 3 with sel 0 leaves the pointer at 3
        req = 4'b1000; req_sel = 16'h0000;
        step();
        chk("ev3_gnt", 32'(gnt), 32'h8);
        req = '0;
        step();
        chk("ev3_data", 32'(rsp_data), 1);
        chk("ev3_id", 32'(rsp_id), 3);

        // All requesters busy: 0,1,2,3,0, requester i selects entry i
        req = 4'b1111; req_sel = 16'h3210;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
            chk("rr_sel", 32'(LUT_sel), 32'(k % 4));
            req[k % 4] = 1'b0;
            step();
            chk("rr_valid", 32'(rsp_valid), 1);
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_data", 32'(rsp_data), (k % 4 == 0) ? 1 : 0);
            chk("rr_gap", 32'(gnt), 0);
            req[k % 4] = 1'b1;
        end
        req = '0;
        step();

        // Requests before any table load are held off
        do_reset();
        req = 4'b0010; req_sel = 16'h0070;
        step(); step(); step();
        chk("uncfg_gnt", 32'(gnt), 0);
        chk("uncfg_cfgd", 32'(configured), 0);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("pend_load_gnt", 32'(gnt), 0);
        shift_bits(16'h00FF, 16'h0000, "load2");
        chk("pend_done_gnt", 32'(gnt), 0);
        step();
        chk("pend_gnt", 32'(gnt), 32'h2);
        chk("pend_sel", 32'(LUT_sel), 32'h7);
        req = '0;
        step();
        chk("pend_data", 32'(rsp_data), 1);
        chk("pend_id", 32'(rsp_id), 1);

        // cfg_start beats req in the same IDLE cycle
        req = 4'b0001; req_sel = 16'h0009; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("prio_ready", 32'(cfg_ready), 1);
        chk("prio_gnt", 32'(gnt), 0);
        shift_bits(16'h00FF, 16'h00FF, "load3");
        chk("prio_done_gnt", 32'(gnt), 0);
        step();
        chk("prio_gnt_after", 32'(gnt), 32'h1);
        req = '0;
        step();
        chk("prio_data", 32'(rsp_data), 0);
        chk("prio_id", 32'(rsp_id), 0);

        // Partial load, restart, full load of A5A5
        done_seen = 0;
        sel_hold = 16'hA5A5;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = sel_hold[15 - i];
            step();
        end
        cfg_valid = 1'b0;
        chk("restart_hold", 32'(LUT_input), 32'h00FF);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("restart_ready", 32'(cfg_ready), 1);
        shift_bits(16'hA5A5, 16'h00FF, "load4");
        step();
        chk("restart_one_done", 32'(done_seen), 1);

        // Reset in the EVAL cycle drops the response and the table
        req = 4'b0100; req_sel = 16'h0100;
        step();
        chk("rst_eval_gnt", 32'(gnt), 32'h4);
        rst = 1'b1; req = '0;
        step();
        chk_all_zero("rst_eval");
        rst = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_gnt", 32'(gnt), 0);
            chk("post_rst_rspv", 32'(rsp_valid), 0);
        end
        chk("post_rst_cfgd", 32'(configured), 0);
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
